// File: rtl/line_buffer_3row.sv
// Raster-to-column window feeder: keeps the two previous image rows in line
// memories and emits the vertical pixel triple (r-2, r-1, r) for each accepted pixel.
module line_buffer_3row #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic                          sof,
    input  logic [PIXEL_WIDTH-1:0]        pix_in,
    output logic                          out_valid,
    output logic [PIXEL_WIDTH-1:0]        pix_top,
    output logic [PIXEL_WIDTH-1:0]        pix_mid,
    output logic [PIXEL_WIDTH-1:0]        pix_bot,
    output logic                          out_sol,
    output logic                          out_eol,
    output logic                          out_eof,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_idx,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_idx
);

    localparam int COLW = $clog2(IMG_WIDTH);
    localparam int ROWW = $clog2(IMG_HEIGHT);
    localparam logic [COLW-1:0] COL_LAST = COLW'(IMG_WIDTH - 1);
    localparam logic [ROWW-1:0] ROW_LAST = ROWW'(IMG_HEIGHT - 1);
    localparam logic [ROWW-1:0] ROW_FIRST_OUT = ROWW'(2);

    // lineA holds row r-2, lineB holds row r-1 at every column
    logic [PIXEL_WIDTH-1:0] line_a [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] line_b [IMG_WIDTH];

    logic [COLW-1:0] col_cnt_reg;
    logic [COLW-1:0] col_cnt_next;
    logic [ROWW-1:0] row_cnt_reg;
    logic [ROWW-1:0] row_cnt_next;
    logic [COLW-1:0] cur_col;
    logic [ROWW-1:0] cur_row;
    logic            cur_emit;

    // sof overrides the counters so the accepted pixel is always (0,0)
    always_comb begin
        cur_col      = sof ? '0 : col_cnt_reg;
        cur_row      = sof ? '0 : row_cnt_reg;
        cur_emit     = (cur_row >= ROW_FIRST_OUT);
        col_cnt_next = cur_col + COLW'(1);
        row_cnt_next = cur_row;
        if (cur_col == COL_LAST) begin
            col_cnt_next = '0;
            row_cnt_next = (cur_row == ROW_LAST) ? '0 : cur_row + ROWW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
        end else if (in_valid) begin
            col_cnt_reg <= col_cnt_next;
            row_cnt_reg <= row_cnt_next;
        end
    end

    // Line memories are not reset; rows 0-1 of any frame re-prime them before use.
    // Nonblocking updates give read-before-write at the shared column address.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            line_a[cur_col] <= line_b[cur_col];
            line_b[cur_col] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            pix_top   <= '0;
            pix_mid   <= '0;
            pix_bot   <= '0;
            row_idx   <= '0;
            col_idx   <= '0;
        end else if (in_valid) begin
            out_valid <= cur_emit;
            out_sol   <= cur_emit && (cur_col == '0);
            out_eol   <= cur_emit && (cur_col == COL_LAST);
            out_eof   <= cur_emit && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
            pix_top   <= line_a[cur_col];
            pix_mid   <= line_b[cur_col];
            pix_bot   <= pix_in;
            row_idx   <= cur_row;
            col_idx   <= cur_col;
        end else begin
            // data and indices hold through input gaps
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Self-checking bench for line_buffer_3row (4x4 image): randomized and directed
// streams compared against a frame-image reference model.
module tb_line_buffer_3row;

    localparam int PW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          sof = 1'b0;
    logic [PW-1:0] pix_in = '0;
    logic          out_valid, out_sol, out_eol, out_eof;
    logic [PW-1:0] pix_top, pix_mid, pix_bot;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;

    int errors = 0;
    int checks = 0;

    line_buffer_3row #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sof(sof), .pix_in(pix_in),
        .out_valid(out_valid), .pix_top(pix_top), .pix_mid(pix_mid), .pix_bot(pix_bot),
        .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof),
        .row_idx(row_idx), .col_idx(col_idx)
    );

    always #5 clk = ~clk;

    // Reference model: the current frame stored as a 2-D image by raster position
    logic [PW-1:0] img [H][W];
    int            m_row = 0;
    int            m_col = 0;
    logic          e_valid = 0, e_sol = 0, e_eol = 0, e_eof = 0;
    logic [PW-1:0] e_top = '0, e_mid = '0, e_bot = '0;
    logic [1:0]    e_row = '0, e_col = '0;

    function automatic logic [31:0] obs();
        return {out_valid, out_sol, out_eol, out_eof, row_idx, col_idx,
                e_valid ? pix_top : 8'h00, e_valid ? pix_mid : 8'h00, pix_bot};
    endfunction

    function automatic logic [31:0] expv();
        return {e_valid, e_sol, e_eol, e_eof, e_row, e_col,
                e_valid ? e_top : 8'h00, e_valid ? e_mid : 8'h00, e_bot};
    endfunction

    task automatic model_reset();
        m_row = 0; m_col = 0;
        e_valid = 0; e_sol = 0; e_eol = 0; e_eof = 0;
        e_top = '0; e_mid = '0; e_bot = '0; e_row = '0; e_col = '0;
    endtask

    // Drive one cycle at the falling edge, update the model, sample 1 ns after the rising edge
    task automatic step(input logic v, input logic s, input logic [PW-1:0] p);
        @(negedge clk);
        in_valid = v; sof = s; pix_in = p;
        if (v) begin
            if (s) begin m_row = 0; m_col = 0; end
            img[m_row][m_col] = p;
            e_valid = (m_row >= 2);
            if (m_row >= 2) begin
                e_top = img[m_row-2][m_col];
                e_mid = img[m_row-1][m_col];
            end
            e_bot = p;
            e_sol = e_valid && (m_col == 0);
            e_eol = e_valid && (m_col == W-1);
            e_eof = e_valid && (m_col == W-1) && (m_row == H-1);
            e_row = 2'(m_row); e_col = 2'(m_col);
            m_col = m_col + 1;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row + 1) % H;
            end
        end else begin
            e_valid = 0; e_sol = 0; e_eol = 0; e_eof = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [PW-1:0] px;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_sol, out_eol, out_eof, pix_top, pix_mid, pix_bot, row_idx, col_idx} !== '0) begin
            errors++;
            $display("FAIL reset_initial: got valid=%b top=%h mid=%h bot=%h row=%0d col=%0d, expected all zero",
                     out_valid, pix_top, pix_mid, pix_bot, row_idx, col_idx);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 10; i++) step(1'b1, i == 0, 8'($urandom));
        // asynchronous assertion between edges
        #2;
        rst_n = 0;
        in_valid = 0;
        #1;
        checks++;
        if ({out_valid, out_sol, out_eol, out_eof, pix_top, pix_mid, pix_bot, row_idx, col_idx} !== '0) begin
            errors++;
            $display("FAIL reset_async: got valid=%b top=%h mid=%h bot=%h row=%0d col=%0d, expected all zero",
                     out_valid, pix_top, pix_mid, pix_bot, row_idx, col_idx);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3*W; i++) begin
            px = 8'($urandom);
            step(1'b1, 1'b0, px);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_restream px%0d: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_continuous();
        for (int k = 0; k < W*H; k++) begin
            step(1'b1, k == 0, 8'(k));
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL cont px%0d: got %h expected %h", k, obs(), expv());
            end
            if (k == 8) begin
                checks++;
                if ({out_valid, pix_top, pix_mid, pix_bot, out_sol, row_idx, col_idx} !==
                    {1'b1, 8'd0, 8'd4, 8'd8, 1'b1, 2'd2, 2'd0}) begin
                    errors++;
                    $display("FAIL cont_first_triple: got v=%b %0d/%0d/%0d sol=%b r%0d c%0d expected v=1 0/4/8 sol=1 r2 c0",
                             out_valid, pix_top, pix_mid, pix_bot, out_sol, row_idx, col_idx);
                end
            end
            if (k == 15) begin
                checks++;
                if ({out_valid, pix_top, pix_mid, pix_bot, out_eol, out_eof} !==
                    {1'b1, 8'd7, 8'd11, 8'd15, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL cont_last_triple: got v=%b %0d/%0d/%0d eol=%b eof=%b expected v=1 7/11/15 eol=1 eof=1",
                             out_valid, pix_top, pix_mid, pix_bot, out_eol, out_eof);
                end
            end
        end
    endtask

    task automatic test_gapped();
        int triples = 0;
        for (int k = 0; k < W*H; k++) begin
            step(1'b1, k == 0, 8'(k));
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL gap_accept px%0d: got %h expected %h", k, obs(), expv());
            end
            if (out_valid) triples++;
            step(1'b0, 1'($urandom), 8'($urandom));
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL gap_idle px%0d: got %h expected %h", k, obs(), expv());
            end
            if (out_valid) triples++;
        end
        checks++;
        if (triples != 8) begin
            errors++;
            $display("FAIL gap_triple_count: got %0d expected 8", triples);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < W*H; k++) step(1'b1, k == 0, 8'(k));
        for (int k = 0; k < W*H; k++) begin
            step(1'b1, 1'b0, 8'(100 + k));
            checks++;
            if (obs() !== expv() || (out_valid && (pix_top < 100 || pix_mid < 100))) begin
                errors++;
                $display("FAIL b2b px%0d: got %h top=%0d mid=%0d expected %h", 100 + k, obs(),
                         pix_top, pix_mid, expv());
            end
            if (k == 8) begin
                checks++;
                if ({out_valid, pix_top, pix_mid, pix_bot} !== {1'b1, 8'd100, 8'd104, 8'd108}) begin
                    errors++;
                    $display("FAIL b2b_first_triple: got v=%b %0d/%0d/%0d expected v=1 100/104/108",
                             out_valid, pix_top, pix_mid, pix_bot);
                end
            end
        end
    endtask

    task automatic test_mid_sof();
        int lows = 0;
        for (int k = 0; k < 13; k++) step(1'b1, k == 0, 8'(k + 1));
        step(1'b1, 1'b1, 8'd50);
        if (!out_valid) lows++;
        for (int k = 0; k < 2*W - 1; k++) begin
            step(1'b1, 1'b0, 8'(60 + k));
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL midsof px%0d: got %h expected %h", k, obs(), expv());
            end
            if (!out_valid) lows++;
        end
        checks++;
        if (lows != 2*W) begin
            errors++;
            $display("FAIL midsof_suppressed: got %0d low cycles expected %0d", lows, 2*W);
        end
        step(1'b1, 1'b0, 8'd77);
        checks++;
        if ({out_valid, pix_top, row_idx, col_idx} !== {1'b1, 8'd50, 2'd2, 2'd0}) begin
            errors++;
            $display("FAIL midsof_first: got v=%b top=%0d r%0d c%0d expected v=1 top=50 r2 c0",
                     out_valid, pix_top, row_idx, col_idx);
        end
    endtask

    task automatic test_max_value();
        for (int k = 0; k < 2*W*H; k++) begin
            step(1'($urandom_range(0, 3) != 0), k == 0, 8'hFF);
            checks++;
            if (obs() !== expv() || (out_valid && {pix_top, pix_mid, pix_bot} !== 24'hFFFFFF)) begin
                errors++;
                $display("FAIL maxval step%0d: got %h expected %h", k, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        step(1'b1, 1'b1, 8'($urandom));
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 39) == 0), 8'($urandom));
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random step%0d: got %h expected %h", k, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gapped();
        test_back_to_back();
        test_mid_sof();
        test_max_value();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_buffer_3row.md
# line_buffer_3row

Raster-to-column window feeder for the 3x3 convolution stage. It accepts one pixel per accepted cycle in raster order and stores the two previous image rows in line memories. For each incoming pixel it emits the vertical triple (row r-2, row r-1, row r) at the same column on `pix_top`/`pix_mid`/`pix_bot`. It sits directly upstream of the conv stage, which builds its 3x3 window from successive columns.

## Interface
- `PIXEL_WIDTH`, 8, bits per pixel; passed through unmodified, no arithmetic.
- `IMG_WIDTH`, 64, pixels per row; must be at least 3.
- `IMG_HEIGHT`, 64, rows per frame; must be at least 3.
- Local values:
  - `COLW` = clog2(`IMG_WIDTH`).
  - `ROWW` = clog2(`IMG_HEIGHT`).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  `pix_in` is valid this cycle; no backpressure, always accepted.
- `sof`  in  1  start of frame; qualified by `in_valid`; this pixel is row 0, col 0.
- `pix_in`  in  `PIXEL_WIDTH`  raster pixel.
- `out_valid`  out  1  output triple valid.
- `pix_top`  out  `PIXEL_WIDTH`  pixel at (r-2, c).
- `pix_mid`  out  `PIXEL_WIDTH`  pixel at (r-1, c).
- `pix_bot`  out  `PIXEL_WIDTH`  pixel at (r, c); this is the delayed `pix_in`.
- `out_sol`  out  1  with `out_valid`: c == 0.
- `out_eol`  out  1  with `out_valid`: c == `IMG_WIDTH`-1.
- `out_eof`  out  1  with `out_valid`: last pixel of the frame.
- `row_idx`  out  `ROWW`  r of the current output.
- `col_idx`  out  `COLW`  c of the current output.

## Operation
- Storage: two line memories, `lineA` (row r-2) and `lineB` (row r-1), each `IMG_WIDTH` x `PIXEL_WIDTH`. Memories are not reset.
- Counters:
  - `col_cnt` 0..`IMG_WIDTH`-1.
  - `row_cnt` 0..`IMG_HEIGHT`-1.
  - Both index the pixel being accepted.
- On accepted pixel (`in_valid`=1) at column c:
  - Register outputs: `pix_top` <= `lineA`[c], `pix_mid` <= `lineB`[c], `pix_bot` <= `pix_in`.
  - Memory update: `lineA`[c] <= `lineB`[c], `lineB`[c] <= `pix_in`. This is a read-before-write at the same address.
  - `out_valid` <= (row >= 2). Rows 0 and 1 only prime the buffers.
  - Flags `out_sol`, `out_eol` and `out_eof`, plus `row_idx`/`col_idx`, are registered from the accepted pixel's row and column. Flags are gated by the same validity as `out_valid`.
  - Counter advance: `col_cnt` increments and wraps to 0 after `IMG_WIDTH`-1. On wrap, `row_cnt` increments, then wraps to 0 after `IMG_HEIGHT`-1 (frame end).
- `sof`=1 with `in_valid`:
  - The pixel is forced to row 0, col 0, regardless of counter state. Counters then advance to col 1 (row 0).
  - Effect: `out_valid` stays low for the next 2*`IMG_WIDTH` accepted pixels, including this one.
  - `sof` without `in_valid` is ignored.
- Frame wrap without `sof`: the next pixel is row 0. Rows 0–1 of the new frame are suppressed, so no triple mixes two frames.
- `in_valid`=0:
  - `out_valid` and all flags <= 0.
  - `pix_*`, `row_idx` and `col_idx` hold their last values.
  - Counters and memories unchanged.
- Reset:
  - All outputs are 0 and counters are 0.
  - The first accepted pixel after reset is row 0, col 0, even without `sof`.
  - Reset mid-row discards the partial frame.

## Timing
- Latency: 1 cycle from the accepted `pix_in` to `pix_bot`/`out_valid`.
- Throughput: 1 pixel per clock sustained; arbitrary `in_valid` gaps are allowed.
- Memory: a read and a write at the same address in the same cycle must return the old data. Either registered-output memory with bypass, or distributed/flop storage, is acceptable.
- `out_valid` is a 1-cycle pulse per accepted valid pixel. The consumer must sample every `out_valid` cycle; no stall is available.
- Asserting `rst_n` low takes effect immediately and asynchronously. Release is synchronous to `clk`; operation resumes on the first edge after release.

## Test plan
- Reset:
  - Drive `rst_n`=0 mid-stream -> all outputs 0 immediately.
  - Release, then stream without `sof` -> first output appears after 2*`IMG_WIDTH` accepted pixels.
- Continuous frame (W=4, H=4): pixels 0..15, `sof` on pixel 0.
  - `out_valid` low for pixels 0–7.
  - Cycle after pixel 8: top=0, mid=4, bot=8, `out_sol`=1, row 2, col 0.
  - Cycle after pixel 15: top=7, mid=11, bot=15, `out_eol`=1, `out_eof`=1.
- Gapped input: same stream with `in_valid` alternating 1/0.
  - Same 8 triples in the same order.
  - `out_valid` high only on the cycle after each accepted pixel.
  - Outputs hold during gaps.
- Back-to-back frames, no second `sof`: frame 2 = pixels 100..115.
  - `out_valid` low for 100–107.
  - First triple: top=100, mid=104, bot=108. No frame-1 values appear.
- Mid-frame `sof`: assert `sof` at row 3, col 1 with pixel 50.
  - `out_valid` low for the next 8 accepted pixels.
  - Then top=50, and `row_idx`=2, `col_idx`=0.
- Max-value pass-through: stream all pixels = 2^`PIXEL_WIDTH`-1 -> every output equals that value, no sign or width alteration.
